// File: rtl/pwm_meter_pkg.sv
// Shared constants, state type and counter helper for the PWM period meter.
package pwm_meter_pkg;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [7:0] ADDR_CTRL    = 8'h50;
  localparam logic [7:0] ADDR_STATUS  = 8'h51;
  localparam logic [7:0] ADDR_ZERO0   = 8'h52;
  localparam logic [7:0] ADDR_ZERO1   = 8'h53;
  localparam logic [7:0] ADDR_ZERO2   = 8'h54;
  localparam logic [7:0] ADDR_ZERO3   = 8'h55;
  localparam logic [7:0] ADDR_SIGNAL0 = 8'h56;
  localparam logic [7:0] ADDR_SIGNAL1 = 8'h57;
  localparam logic [7:0] ADDR_SIGNAL2 = 8'h58;
  localparam logic [7:0] ADDR_SIGNAL3 = 8'h59;
  localparam logic [7:0] ADDR_PERIODS = 8'h5A;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_CLR  = 1;
  localparam int CTRL_HOLD = 2;

  localparam int ST_READY  = 0;
  localparam int ST_OVF    = 1;
  localparam int ST_MISSED = 2;

  typedef enum logic [1:0] {IDLE, SYNC, LOW, HIGH} state_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pwm_meter_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, plus rise/fall detection
// against the previous synchronized value.
module sync_edge (
  input  logic clk,
  input  logic res,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/pwm_meter.sv
// PWM period meter: times the low and high phases of a synchronized input
// and publishes each completed period through a byte-wide register file.
module pwm_meter
  import pwm_meter_pkg::*;
#(
  parameter logic [CNT_W-1:0] LOW_INIT = CNT_W'(1)
) (
  input  logic       clk,
  input  logic       res,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  input  logic       we,
  output logic [7:0] data_out,
  input  logic       in,
  output logic       done
);

  logic in_level, in_rise, in_fall;

  sync_edge u_sync (
    .clk   (clk),
    .res   (res),
    .in    (in),
    .level (in_level),
    .rise  (in_rise),
    .fall  (in_fall)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d, high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] zero_q, zero_d, signal_q, signal_d;
  logic [7:0]       periods_q, periods_d, data_out_q, data_out_d;
  logic [2:0]       ctrl_q, ctrl_d, status_q, status_d;
  logic             done_q, done_d;

  logic       wr_ctrl, wr_status, complete, ovf_set;
  logic [2:0] status_set;
  logic       unused_bits;

  assign wr_ctrl     = we && (addr == ADDR_CTRL);
  assign wr_status   = we && (addr == ADDR_STATUS);
  assign unused_bits = ^{data_in[7:3], in_level};

  always_comb begin
    state_d    = state_q;
    low_cnt_d  = low_cnt_q;
    high_cnt_d = high_cnt_q;
    complete   = 1'b0;
    ovf_set    = 1'b0;
    if (!ctrl_q[CTRL_EN]) begin
      state_d    = IDLE;
      low_cnt_d  = '0;
      high_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = SYNC;
          low_cnt_d  = '0;
          high_cnt_d = '0;
        end
        SYNC: begin
          // A rise here belongs to a period whose start we never saw.
          if (in_fall) begin
            state_d   = LOW;
            low_cnt_d = LOW_INIT;
          end
        end
        LOW: begin
          if (in_rise) begin
            state_d    = HIGH;
            high_cnt_d = CNT_W'(1);
          end else begin
            low_cnt_d = sat_inc(low_cnt_q);
            ovf_set   = (low_cnt_q == CNT_MAX);
          end
        end
        HIGH: begin
          if (in_fall) begin
            state_d    = LOW;
            low_cnt_d  = LOW_INIT;
            high_cnt_d = '0;
            complete   = 1'b1;
          end else begin
            high_cnt_d = sat_inc(high_cnt_q);
            ovf_set    = (high_cnt_q == CNT_MAX);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    zero_d     = zero_q;
    signal_d   = signal_q;
    periods_d  = periods_q;
    status_set = 3'b000;
    if (complete) begin
      periods_d = periods_q + 8'd1;
      if (ctrl_q[CTRL_HOLD]) begin
        status_set[ST_MISSED] = 1'b1;
      end else begin
        zero_d               = low_cnt_q;
        signal_d             = high_cnt_q;
        status_set[ST_READY] = 1'b1;
      end
    end
    status_set[ST_OVF] = ovf_set;
    // Write-one-to-clear, but a same-cycle set event wins.
    status_d = (status_q & ~(wr_status ? data_in[2:0] : 3'b000)) | status_set;
    ctrl_d   = ctrl_q;
    done_d   = complete;
    if (wr_ctrl) begin
      ctrl_d = {data_in[CTRL_HOLD], 1'b0, data_in[CTRL_EN]};
      if (data_in[CTRL_CLR]) begin
        zero_d    = '0;
        signal_d  = '0;
        periods_d = '0;
        status_d  = '0;
      end
    end
  end

  always_comb begin
    data_out_d = 8'h00;
    case (addr)
      ADDR_CTRL:    data_out_d = {5'b0, ctrl_q};
      ADDR_STATUS:  data_out_d = {5'b0, status_q};
      ADDR_ZERO0:   data_out_d = zero_q[7:0];
      ADDR_ZERO1:   data_out_d = zero_q[15:8];
      ADDR_ZERO2:   data_out_d = zero_q[23:16];
      ADDR_ZERO3:   data_out_d = zero_q[31:24];
      ADDR_SIGNAL0: data_out_d = signal_q[7:0];
      ADDR_SIGNAL1: data_out_d = signal_q[15:8];
      ADDR_SIGNAL2: data_out_d = signal_q[23:16];
      ADDR_SIGNAL3: data_out_d = signal_q[31:24];
      ADDR_PERIODS: data_out_d = periods_q;
      default:      data_out_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= IDLE;
      low_cnt_q  <= '0;
      high_cnt_q <= '0;
      zero_q     <= '0;
      signal_q   <= '0;
      periods_q  <= '0;
      ctrl_q     <= '0;
      status_q   <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      low_cnt_q  <= low_cnt_d;
      high_cnt_q <= high_cnt_d;
      zero_q     <= zero_d;
      signal_q   <= signal_d;
      periods_q  <= periods_d;
      ctrl_q     <= ctrl_d;
      status_q   <= status_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

  assign data_out = data_out_q;
  assign done     = done_q;

endmodule
